hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_if.sv | 40 ++++
 rtl/hazard_controller.sv | 108 ++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-unit bundle: register numbers and control bits in,
// forwarding selects, stall/flush controls and multi-cycle status out.
interface hazard_controller_if;
    logic [4:0]  Rs1_E;
    logic [4:0]  Rs2_E;
    logic [4:0]  Rs1_D;
    logic [4:0]  Rs2_D;
    logic [4:0]  RD_E;
    logic [4:0]  RD_M;
    logic [4:0]  RD_W;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        ResultSrcE;
    logic        PCSrcE;
    logic        MulStartE;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        FlushD;
    logic        FlushE;
    logic        MulBusy;
    logic        MulDoneE;
    logic [15:0] StallCount;

    modport master (
        output Rs1_E, Rs2_E, Rs1_D, Rs2_D, RD_E, RD_M, RD_W,
               RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE,
        input  ForwardA_E, ForwardB_E, StallF, StallD, StallE,
               FlushD, FlushE, MulBusy, MulDoneE, StallCount
    );

    modport slave (
        input  Rs1_E, Rs2_E, Rs1_D, Rs2_D, RD_E, RD_M, RD_W,
               RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE,
        output ForwardA_E, ForwardB_E, StallF, StallD, StallE,
               FlushD, FlushE, MulBusy, MulDoneE, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and
// multi-cycle-op stalls, branch flushes and a saturating stall counter.
module hazard_controller #(
    parameter int MUL_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave hz
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_mul_busy;
    logic        r_mul_done;
    logic [15:0] r_stall_count;

    logic [4:0]  w_rs_e [2];
    logic [1:0]  w_fwd  [2];
    logic        w_lw_stall;
    logic        w_mc_stall;
    logic        w_stall_fd;
    logic        w_flush_d;
    logic        w_flush_e;

    assign w_rs_e[0] = hz.Rs1_E;
    assign w_rs_e[1] = hz.Rs2_E;

    // M stage wins over W since it holds the younger result.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] =
                (hz.RegWriteM && (hz.RD_M != 5'd0) && (hz.RD_M == w_rs_e[gi])) ? 2'b10 :
                (hz.RegWriteW && (hz.RD_W != 5'd0) && (hz.RD_W == w_rs_e[gi])) ? 2'b01 :
                                                                                 2'b00;
        end
    endgenerate

    assign hz.ForwardA_E = w_fwd[0];
    assign hz.ForwardB_E = w_fwd[1];

    always_comb begin
        w_lw_stall = hz.ResultSrcE && (hz.RD_E != 5'd0) &&
                     ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));
        w_mc_stall = ((r_state == IDLE) && hz.MulStartE) || (r_state == BUSY);
        w_stall_fd = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        if (!rst) begin
            w_stall_fd = (w_lw_stall || w_mc_stall) && !hz.PCSrcE;
            w_flush_d  = hz.PCSrcE && !w_mc_stall;
            w_flush_e  = (w_lw_stall || hz.PCSrcE) && !w_mc_stall;
        end
    end

    assign hz.StallF     = w_stall_fd;
    assign hz.StallD     = w_stall_fd;
    assign hz.StallE     = w_mc_stall && !rst;
    assign hz.FlushD     = w_flush_d;
    assign hz.FlushE     = w_flush_e;
    assign hz.MulBusy    = r_mul_busy;
    assign hz.MulDoneE   = r_mul_done && !rst;
    assign hz.StallCount = r_stall_count;

    // BUSY is held for MUL_LAT-2 cycles so the op occupies E for MUL_LAT
    // cycles in total: one start cycle, the BUSY run, then DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_mul_busy    <= 1'b0;
            r_mul_done    <= 1'b0;
            r_stall_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (hz.MulStartE) begin
                        r_state    <= BUSY;
                        r_cnt      <= 4'(MUL_LAT - 3);
                        r_mul_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state    <= DONE;
                        r_mul_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_mul_busy <= 1'b0;
                    r_mul_done <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_mul_busy <= 1'b0;
                    r_mul_done <= 1'b0;
                end
            endcase
            if (w_stall_fd && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end
endmodule
